// File: rtl/ref_row_fetcher_if.sv
// Start/memory/row bus of the reference row fetcher.
// master is the fetcher side; slave is its environment (frame memory and consumer).
interface ref_row_fetcher_if #(
  parameter int ADDR_W  = 12,
  parameter int COORD_W = 8,
  parameter int ROW_PIX = 15
);
  logic                      start;
  logic signed [COORD_W-1:0] blk_x;
  logic signed [COORD_W-1:0] blk_y;
  logic                      busy;
  logic                      mem_rd;
  logic [ADDR_W-1:0]         mem_addr;
  logic [7:0]                mem_rdata;
  logic [8*ROW_PIX-1:0]      row_data;
  logic                      row_valid;
  logic                      row_ready;
  logic [3:0]                row_idx;
  logic                      blk_done;

  modport master (
    input  start, blk_x, blk_y, mem_rdata, row_ready,
    output busy, mem_rd, mem_addr, row_data, row_valid, row_idx, blk_done
  );

  modport slave (
    output start, blk_x, blk_y, mem_rdata, row_ready,
    input  busy, mem_rd, mem_addr, row_data, row_valid, row_idx, blk_done
  );
endinterface

// File: rtl/ref_row_fetcher.sv
// Fetches the edge-padded (BLK+TAPS-1)^2 reference window around a block, one pixel
// per read, and hands it downstream one packed row at a time.
module ref_row_fetcher #(
  parameter int FRAME_W = 64,
  parameter int FRAME_H = 64,
  parameter int ADDR_W  = 12,
  parameter int COORD_W = 8,
  parameter int BLK     = 8,
  parameter int TAPS    = 8
) (
  input logic               clk,
  input logic               rst,
  ref_row_fetcher_if.master bus
);
  localparam int ROW_PIX = BLK + TAPS - 1;
  localparam int CW      = COORD_W + 2;
  localparam logic signed [CW-1:0] XMAX = CW'(FRAME_W - 1);
  localparam logic signed [CW-1:0] YMAX = CW'(FRAME_H - 1);
  localparam logic signed [CW-1:0] HALF = CW'(TAPS/2 - 1);

  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, PRESENT, DONE} state_t;

  state_t                state_q, state_d;
  logic signed [CW-1:0]  ox_q, ox_d, oy_q, oy_d;
  logic [3:0]            row_q, row_d, col_q, col_d;
  logic                  rd_pend_q;
  logic [3:0]            rd_col_q;
  logic [8*ROW_PIX-1:0]  row_data_q;

  logic signed [CW-1:0]  x, y;
  logic [ADDR_W-1:0]     cx, cy;
  logic                  rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ox_q    <= '0;
      oy_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ox_d    = ox_q;
    oy_d    = oy_q;
    row_d   = row_q;
    col_d   = col_q;
    unique case (state_q)
      IDLE: if (bus.start) begin
        state_d = FETCH;
        ox_d    = $signed({{2{bus.blk_x[COORD_W-1]}}, bus.blk_x}) - HALF;
        oy_d    = $signed({{2{bus.blk_y[COORD_W-1]}}, bus.blk_y}) - HALF;
        row_d   = '0;
        col_d   = '0;
      end
      FETCH: begin
        if (col_q == 4'(ROW_PIX - 1)) begin
          state_d = DRAIN;
          col_d   = '0;
        end else begin
          col_d = col_q + 4'd1;
        end
      end
      DRAIN: state_d = PRESENT;
      PRESENT: if (bus.row_ready) begin
        if (row_q == 4'(ROW_PIX - 1)) begin
          state_d = DONE;
        end else begin
          state_d = FETCH;
          row_d   = row_q + 4'd1;
          col_d   = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Edge padding: clamp the signed window coordinate into the frame, never wrap.
  always_comb begin
    x  = ox_q + $signed({{(CW-4){1'b0}}, col_q});
    y  = oy_q + $signed({{(CW-4){1'b0}}, row_q});
    cx = '0;
    cy = '0;
    if (x > XMAX)       cx = ADDR_W'(FRAME_W - 1);
    else if (x >= 0)    cx = ADDR_W'(x);
    if (y > YMAX)       cy = ADDR_W'(FRAME_H - 1);
    else if (y >= 0)    cy = ADDR_W'(y);
  end

  assign rd = (state_q == FETCH);

  // Responses land one cycle after their read; a reset drops any pending one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_q  <= 1'b0;
      rd_col_q   <= '0;
      row_data_q <= '0;
    end else begin
      rd_pend_q <= rd;
      rd_col_q  <= col_q;
      if (rd_pend_q) row_data_q[8*rd_col_q +: 8] <= bus.mem_rdata;
    end
  end

  assign bus.busy      = (state_q == FETCH) || (state_q == DRAIN) || (state_q == PRESENT);
  assign bus.mem_rd    = rd;
  assign bus.mem_addr  = rd ? ADDR_W'(cy * ADDR_W'(FRAME_W) + cx) : '0;
  assign bus.row_data  = row_data_q;
  assign bus.row_valid = (state_q == PRESENT);
  assign bus.row_idx   = row_q;
  assign bus.blk_done  = (state_q == DONE);
endmodule
